hazard_unit: RTL and testbench

Produces the 3-bit `hazard` code consumed by the control decoder and sequences pipeline stalls for the 16-bit CPU. Sits beside the ID stage. Compares branch operands and reports taken/not-taken as the code that the control decoder turns into `if_flush`/`pc_src`. Detects load-use and branch-on-EX-result dependencies and holds the front end while multi-cycle multiply/divide runs in EX. Latches a halt instruction until reset.

---
 rtl/hazard_unit_pkg.sv | 36 +++
 rtl/hazard_unit_branch_compare.sv | 32 +++
 rtl/hazard_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared ISA constants, hazard codes and hazard-unit FSM state type,
// also consumed by the control decoder.
package hazard_unit_pkg;

    localparam logic [3:0] OP_ATYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;
    localparam logic [3:0] OP_LB    = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] FN_MUL   = 4'b0100;
    localparam logic [3:0] FN_DIV   = 4'b1000;

    localparam logic [2:0] HZ_NONE  = 3'b000;
    localparam logic [2:0] HZ_BLT   = 3'b001;
    localparam logic [2:0] HZ_BGT   = 3'b010;
    localparam logic [2:0] HZ_BEQ   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_HALTED  = 2'd2
    } hz_state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BLT) || (op == OP_BGT) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_unit_branch_compare.sv
// Combinational signed comparator turning a branch opcode and its two
// register operands into the taken/not-taken hazard code.
module branch_compare
    import hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OP_WIDTH     = 4,
    parameter int HAZARD_WIDTH = 3
) (
    input  logic [OP_WIDTH-1:0]     opcode,
    input  logic [DATA_WIDTH-1:0]   op1,
    input  logic [DATA_WIDTH-1:0]   op2,
    output logic [HAZARD_WIDTH-1:0] hazard
);

    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;

    assign a = op1;
    assign b = op2;

    always_comb begin
        hazard = HAZARD_WIDTH'(HZ_NONE);
        case (opcode)
            OP_BLT:  if (a < b)  hazard = HAZARD_WIDTH'(HZ_BLT);
            OP_BGT:  if (a > b)  hazard = HAZARD_WIDTH'(HZ_BGT);
            OP_BEQ:  if (a == b) hazard = HAZARD_WIDTH'(HZ_BEQ);
            default: hazard = HAZARD_WIDTH'(HZ_NONE);
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-dependency stall logic, multi-cycle mult/div front-end
// hold and halt latch for the 16-bit CPU; branch outcome comes from branch_compare.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int OP_WIDTH       = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int HAZARD_WIDTH   = 3,
    parameter int MULT_CYCLES    = 4,
    parameter int DIV_CYCLES     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OP_WIDTH-1:0]       id_opcode,
    input  logic [FUNC_WIDTH-1:0]     id_funct,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [DATA_WIDTH-1:0]     id_op1,
    input  logic [DATA_WIDTH-1:0]     id_op2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_reg_write,
    output logic [HAZARD_WIDTH-1:0]   hazard,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      id_ex_bubble,
    output logic                      md_start,
    output logic                      md_is_div,
    output logic                      halted
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    hz_state_t               state;
    hz_state_t               state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    use_rs1;
    logic                    use_rs2;
    logic                    is_br;
    logic                    is_md;
    logic                    ld_use;
    logic                    br_dep;
    logic                    stall;
    logic [HAZARD_WIDTH-1:0] br_code;

    branch_compare #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OP_WIDTH     (OP_WIDTH),
        .HAZARD_WIDTH (HAZARD_WIDTH)
    ) u_branch_compare (
        .opcode (id_opcode),
        .op1    (id_op1),
        .op2    (id_op2),
        .hazard (br_code)
    );

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            OP_ATYPE, OP_BLT, OP_BGT, OP_BEQ, OP_SW, OP_SB: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_LW, OP_LB: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign is_br  = is_branch(id_opcode);
    assign is_md  = (id_opcode == OP_ATYPE) && ((id_funct == FN_MUL) || (id_funct == FN_DIV));
    assign ld_use = ex_mem_read && ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
    // Branch compare reads the register file directly, so any EX writer to a source must stall.
    assign br_dep = is_br && ex_reg_write && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign stall  = ld_use || br_dep || (state == ST_MD_BUSY);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        md_start     = 1'b0;
        md_is_div    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        hazard       = br_code;
        case (state)
            ST_IDLE: begin
                if (stall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    hazard       = HAZARD_WIDTH'(HZ_NONE);
                end else if (is_md) begin
                    md_start   = 1'b1;
                    md_is_div  = id_funct[3];
                    cnt_next   = id_funct[3] ? DIV_LOAD : MULT_LOAD;
                    state_next = ST_MD_BUSY;
                end else if (id_opcode == OP_HALT) begin
                    state_next = ST_HALTED;
                end
            end
            ST_MD_BUSY: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                hazard       = HAZARD_WIDTH'(HZ_NONE);
                if (cnt != '0) cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_next = ST_IDLE;
            end
            ST_HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                hazard       = HAZARD_WIDTH'(HZ_NONE);
            end
            default: state_next = ST_IDLE;
        endcase
        // Outputs are combinational, so reset must override them directly while asserted.
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            md_start     = 1'b0;
            md_is_div    = 1'b0;
            hazard       = HAZARD_WIDTH'(HZ_NONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign halted = (state == ST_HALTED) && !rst;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: branch codes, load-use and branch stalls,
// mult/div hold lengths, halt latch and asynchronous reset.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  id_opcode = '0;
    logic [3:0]  id_funct = '0;
    logic [3:0]  id_rs1 = '0;
    logic [3:0]  id_rs2 = '0;
    logic [15:0] id_op1 = '0;
    logic [15:0] id_op2 = '0;
    logic [3:0]  ex_rd = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic [2:0]  hazard;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        md_start;
    logic        md_is_div;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_op1       (id_op1),
        .id_op2       (id_op2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .hazard       (hazard),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp_stall);
        chk({tag, ".pc_write"},     16'(pc_write),     16'(!exp_stall));
        chk({tag, ".if_id_write"},  16'(if_id_write),  16'(!exp_stall));
        chk({tag, ".id_ex_bubble"}, 16'(id_ex_bubble), 16'(exp_stall));
    endtask

    task automatic set_id(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [15:0] a, input logic [15:0] b);
        id_opcode = op; id_funct = fn; id_rs1 = r1; id_rs2 = r2; id_op1 = a; id_op2 = b;
    endtask

    task automatic set_ex(input logic [3:0] rd, input logic mr, input logic rw);
        ex_rd = rd; ex_mem_read = mr; ex_reg_write = rw;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state while rst held
        #2;
        chk_stall("reset", 1'b1);
        chk("reset.hazard", 16'(hazard), 16'(HZ_NONE));
        chk("reset.halted", 16'(halted), 16'd0);
        chk("reset.md_start", 16'(md_start), 16'd0);
        cyc(); cyc();
        rst = 1'b0;

        // BLT -2 < 3 taken, swapped not taken
        set_ex(4'd0, 1'b0, 1'b0);
        set_id(OP_BLT, 4'd0, 4'd1, 4'd2, 16'hFFFE, 16'h0003);
        #2;
        chk("blt_taken.hazard", 16'(hazard), 16'(HZ_BLT));
        chk_stall("blt_taken", 1'b0);
        cyc();
        set_id(OP_BLT, 4'd0, 4'd1, 4'd2, 16'h0003, 16'hFFFE);
        #2;
        chk("blt_not.hazard", 16'(hazard), 16'(HZ_NONE));
        cyc();
        set_id(OP_BGT, 4'd0, 4'd1, 4'd2, 16'h0005, 16'hFFFD);
        #2;
        chk("bgt_taken.hazard", 16'(hazard), 16'(HZ_BGT));
        cyc();
        set_id(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'h8000, 16'h7FFF);
        #2;
        chk("beq_not.hazard", 16'(hazard), 16'(HZ_NONE));

        // Load-use on rs2 of an add
        cyc();
        set_ex(4'd5, 1'b1, 1'b1);
        set_id(OP_ATYPE, 4'd0, 4'd1, 4'd5, 16'd0, 16'd0);
        #2;
        chk_stall("ld_use", 1'b1);
        cyc();
        set_ex(4'd5, 1'b0, 1'b0);
        #2;
        chk_stall("ld_use_clear", 1'b0);
        // ORI does not read rs2, so a matching rs2 is not a dependency
        cyc();
        set_ex(4'd5, 1'b1, 1'b1);
        set_id(OP_ORI, 4'd0, 4'd1, 4'd5, 16'd0, 16'd0);
        #2;
        chk_stall("ori_rs2_nodep", 1'b0);

        // Branch on EX result stalls; plain ALU consumer does not
        cyc();
        set_ex(4'd3, 1'b0, 1'b1);
        set_id(OP_BEQ, 4'd0, 4'd3, 4'd4, 16'h0007, 16'h0007);
        #2;
        chk("br_dep.hazard", 16'(hazard), 16'(HZ_NONE));
        chk_stall("br_dep", 1'b1);
        cyc();
        set_ex(4'd0, 1'b0, 1'b0);
        #2;
        chk("br_dep_clear.hazard", 16'(hazard), 16'(HZ_BEQ));
        chk_stall("br_dep_clear", 1'b0);
        cyc();
        set_ex(4'd3, 1'b0, 1'b1);
        set_id(OP_ATYPE, 4'd0, 4'd3, 4'd4, 16'd0, 16'd0);
        #2;
        chk_stall("alu_fwd_nodep", 1'b0);

        // Multiply: launch, then exactly 3 held cycles
        cyc();
        set_ex(4'd0, 1'b0, 1'b0);
        set_id(OP_ATYPE, FN_MUL, 4'd1, 4'd2, 16'd0, 16'd0);
        #2;
        chk("mul.md_start", 16'(md_start), 16'd1);
        chk("mul.md_is_div", 16'(md_is_div), 16'd0);
        chk_stall("mul_launch", 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_id(OP_ATYPE, FN_MUL, 4'd1, 4'd2, 16'd0, 16'd0);
            #2;
            chk_stall("mul_busy", 1'b1);
            chk("mul_busy.md_start", 16'(md_start), 16'd0);
            if (i == 2) set_id(OP_ATYPE, 4'd0, 4'd1, 4'd2, 16'd0, 16'd0);
        end
        cyc();
        #2;
        chk_stall("mul_done", 1'b0);

        // Load-use beats a mult launch; launch follows when it clears
        cyc();
        set_ex(4'd6, 1'b1, 1'b1);
        set_id(OP_ATYPE, FN_MUL, 4'd6, 4'd2, 16'd0, 16'd0);
        #2;
        chk("mul_lduse.md_start", 16'(md_start), 16'd0);
        chk_stall("mul_lduse", 1'b1);
        cyc();
        set_ex(4'd0, 1'b0, 1'b0);
        #2;
        chk("mul_after_lduse.md_start", 16'(md_start), 16'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_id(OP_ATYPE, 4'd0, 4'd1, 4'd2, 16'd0, 16'd0);
            #2;
            chk_stall("mul2_busy", 1'b1);
        end
        cyc();
        #2;
        chk_stall("mul2_done", 1'b0);

        // Divide: 7 held cycles with a taken BEQ waiting behind it
        cyc();
        set_id(OP_ATYPE, FN_DIV, 4'd1, 4'd2, 16'd0, 16'd0);
        #2;
        chk("div.md_start", 16'(md_start), 16'd1);
        chk("div.md_is_div", 16'(md_is_div), 16'd1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            set_id(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'h0009, 16'h0009);
            #2;
            chk_stall("div_busy", 1'b1);
            chk("div_busy.hazard", 16'(hazard), 16'(HZ_NONE));
        end
        cyc();
        #2;
        chk_stall("div_done", 1'b0);
        chk("div_done.hazard", 16'(hazard), 16'(HZ_BEQ));

        // Halt latches from the next edge and holds
        cyc();
        set_id(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0);
        #2;
        chk("halt_id.halted", 16'(halted), 16'd0);
        chk_stall("halt_id", 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_id(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'h0001, 16'h0001);
            #2;
            chk("halted.halted", 16'(halted), 16'd1);
            chk("halted.hazard", 16'(hazard), 16'(HZ_NONE));
            chk_stall("halted", 1'b1);
        end
        #1;
        rst = 1'b1;
        #1;
        chk("halt_rst.halted", 16'(halted), 16'd0);
        chk_stall("halt_rst", 1'b1);
        chk("halt_rst.md_start", 16'(md_start), 16'd0);
        cyc();
        rst = 1'b0;
        set_id(OP_ATYPE, 4'd0, 4'd1, 4'd2, 16'd0, 16'd0);
        #2;
        chk_stall("post_halt_rst", 1'b0);
        cyc();
        #2;
        chk("post_halt_rst.halted", 16'(halted), 16'd0);

        // Reset mid-multiply at cnt=2, then a full-length divide
        set_id(OP_ATYPE, FN_MUL, 4'd1, 4'd2, 16'd0, 16'd0);
        #1;
        chk("mul_abort.md_start", 16'(md_start), 16'd1);
        cyc();
        set_id(OP_ATYPE, 4'd0, 4'd1, 4'd2, 16'd0, 16'd0);
        cyc();
        #1;
        chk("mul_abort.cnt", 16'(dut.cnt), 16'd2);
        rst = 1'b1;
        #1;
        chk("mul_abort.state", 16'(dut.state), 16'(ST_IDLE));
        chk_stall("mul_abort", 1'b1);
        cyc();
        rst = 1'b0;
        set_id(OP_ATYPE, FN_DIV, 4'd1, 4'd2, 16'd0, 16'd0);
        #2;
        chk("div2.md_start", 16'(md_start), 16'd1);
        chk("div2.md_is_div", 16'(md_is_div), 16'd1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            set_id(OP_ATYPE, 4'd0, 4'd1, 4'd2, 16'd0, 16'd0);
            #2;
            chk_stall("div2_busy", 1'b1);
        end
        cyc();
        #2;
        chk_stall("div2_done", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
